fir_decimator_mc: RTL
=====================

Name: fir_decimator_mc

Overview:
Multichannel, runtime-configurable FIR decimator for the audio front end. It is the successor to the fixed single-channel decimator. It keeps one circular delay line per channel and loads coefficients at runtime. It computes a filter output only on every D-th input sample, using one time-multiplexed multiply-accumulate engine that processes one tap per cycle. Channel outputs are serialised onto one output stream tagged with a channel index, and feed the downstream FFT/pitch-detection path.

Parameters:
DATA_W, 16, sample width (signed two's complement)
COEF_W, 16, coefficient width (signed, Q1.(COEF_W-1))
NUM_TAPS, 32, filter length (power of two, 4..64)
NUM_CH, 2, number of channels (1..8)
MAX_DEC, 8, maximum decimation factor (2..15)

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
audio_in  in  NUM_CH*DATA_W  packed samples, channel c at bits [c*DATA_W +: DATA_W]
audio_valid_in  in  1  one-cycle strobe; all channels sampled together
dec_factor_in  in  4  requested decimation factor D
coef_we_in  in  1  coefficient write enable
coef_addr_in  in  clog2(NUM_TAPS)  tap index
coef_data_in  in  COEF_W  signed coefficient
dec_out  out  DATA_W  decimated filtered sample
dec_ch_out  out  clog2(NUM_CH) (min 1)  channel of dec_out
dec_valid_out  out  1  one-cycle strobe qualifying dec_out/dec_ch_out
busy_out  out  1  MAC engine active
overrun_out  out  1  sticky: input strobe dropped while busy

Behaviour:
- Reset (asynchronous, any state): dec_out=0, dec_ch_out=0, dec_valid_out=0, busy_out=0, overrun_out=0.
  - Delay lines, coefficient registers, write pointer, phase counter and accumulator are cleared.
  - FSM goes to IDLE.
  - Effective D reloads from dec_factor_in at the first accepted sample.
- Effective D: dec_factor_in of 0 or 1 means 1 (no decimation); values above MAX_DEC clamp to MAX_DEC. D is latched only when the phase counter is 0, so a change takes effect at the next decimation boundary and never mid-period.
- FSM states are IDLE, MAC, OUT.
- IDLE + audio_valid_in:
  - Write each channel's sample at wr_ptr; wr_ptr increments modulo NUM_TAPS.
  - If phase == D-1: phase <= 0, ch <= 0, tap <= 0, acc <= 0, go to MAC, busy_out <= 1.
  - Otherwise phase increments and no output is produced.
- MAC: one tap per cycle, acc += coef[tap] * x[ch][(wr_ptr-1-tap) mod NUM_TAPS], so tap 0 is the newest sample. After tap NUM_TAPS-1, go to OUT.
- Accumulator width is DATA_W+COEF_W+clog2(NUM_TAPS), with full-precision signed products.
- OUT:
  - dec_out = saturate_DATA_W((acc + 2^(COEF_W-2)) >>> (COEF_W-1)), i.e. round half up, then clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - dec_valid_out=1 for exactly this cycle; dec_ch_out=ch.
  - If ch < NUM_CH-1: ch++, tap=0, acc=0, go to MAC. Otherwise go to IDLE with busy_out <= 0.
- Latency:
  - With the accepting edge as cycle 0, channel c's dec_valid_out is high in cycle (c+1)*(NUM_TAPS+1).
  - busy_out falls one cycle after the last OUT.
  - The minimum spacing between decimating samples is NUM_CH*(NUM_TAPS+1)+1 cycles.
- audio_valid_in while busy_out=1: the sample is dropped (no delay-line write, no phase advance) and overrun_out is set. overrun_out clears only on reset.
- Coefficient writes:
  - Accepted in IDLE only; writes while busy are ignored.
  - A write coinciding with an accepted sample in IDLE is applied, and takes effect from the next MAC.
- Outputs other than dec_valid_out hold their last value between strobes.

Test Plan:
- Impulse, NUM_CH=2, D=1, coef[k]=k*256. Drive ch0 impulse 16384 then zeros; ch1 all zero. Expect ch0 output n = k*128 for sample n=k, i.e. 0, 128, 256, …, and ch1 always 0. Outputs alternate ch0/ch1, and ch0 dec_valid_out lands at cycle NUM_TAPS+1 after the accept.
- DC and saturation: all coef=0x7FFF, constant input 32767. Expect 32767 (saturated). Constant input -32768: expect -32768. Small DC input 100 with coef[0]=0x4000 and others 0: expect 50.
- Decimation change: D=4 for 12 samples, giving 3 output groups at samples 4, 8 and 12. Set dec_factor_in=2 mid-period: the next output still arrives on the 4-boundary, after which outputs come every 2 samples. dec_factor_in=0 gives one output per sample; 15 clamps to 8.
- Overrun: D=1 with a strobe 10 cycles after an accept. Expect the sample dropped, overrun_out=1 held, and the delay-line contents unchanged, checked against a golden model that omits the dropped sample.
- Coefficient write while busy: write coef[0]=0x7FFF during MAC. Expect it ignored and the next outputs to match the old coefficients. The same write in IDLE takes effect on the next output.
- Reset mid-MAC: assert rst_in at tap 5 of ch0. Expect all outputs 0 immediately (asynchronous), no dec_valid_out, and coefficients cleared, so the following output is 0 until reload.

Source files
------------

// File: rtl/fir_decimator_mc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fir_decimator_mc
//
// Multichannel, runtime-configurable FIR decimator. Each channel owns a
// circular delay line of NUM_TAPS samples; one shared multiply-accumulate
// engine evaluates one tap per cycle. The filter is only evaluated on every
// D-th accepted input sample. The engine then produces one output per channel,
// serialised onto dec_out and tagged with dec_ch_out.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   audio_in        packed samples, channel c at [c*DATA_W +: DATA_W]
//   audio_valid_in  one-cycle strobe, all channels sampled together
//   dec_factor_in   requested decimation factor (0/1 -> 1, clamps at MAX_DEC)
//   coef_we_in      coefficient write enable (honoured only while idle)
//   coef_addr_in    tap index of the coefficient write
//   coef_data_in    signed Q1.(COEF_W-1) coefficient
//   dec_out         rounded, saturated filter output
//   dec_ch_out      channel index of dec_out
//   dec_valid_out   one-cycle strobe qualifying dec_out/dec_ch_out
//   busy_out        MAC engine active
//   overrun_out     sticky: an input strobe arrived while busy and was dropped
// -----------------------------------------------------------------------------
module fir_decimator_mc #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int NUM_TAPS = 32,
    parameter int NUM_CH   = 2,
    parameter int MAX_DEC  = 8
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic [NUM_CH*DATA_W-1:0]                   audio_in,
    input  logic                                       audio_valid_in,
    input  logic [3:0]                                 dec_factor_in,
    input  logic                                       coef_we_in,
    input  logic [$clog2(NUM_TAPS)-1:0]                coef_addr_in,
    input  logic [COEF_W-1:0]                          coef_data_in,
    output logic [DATA_W-1:0]                          dec_out,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] dec_ch_out,
    output logic                                       dec_valid_out,
    output logic                                       busy_out,
    output logic                                       overrun_out
);

    localparam int TAP_W  = $clog2(NUM_TAPS);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + TAP_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [3:0] MAX_DEC_L = 4'(MAX_DEC);

    // Half an LSB of the output in accumulator units: round half up.
    localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W+1)'(longint'(1) << (COEF_W-2));
    localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((longint'(1) << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN  = (ACC_W+1)'(-(longint'(1) << (DATA_W-1)));

    // Control state
    logic [1:0]              state_q, state_d;
    logic [3:0]              phase_q, phase_d;
    logic [3:0]              d_eff_q, d_eff_d;
    logic [TAP_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;

    // Output registers
    logic [DATA_W-1:0]       dec_out_q, dec_out_d;
    logic [CH_W-1:0]         dec_ch_q, dec_ch_d;
    logic                    dec_valid_q, dec_valid_d;

    // Storage
    logic [DATA_W-1:0]       dline_q [NUM_CH][NUM_TAPS];
    logic [COEF_W-1:0]       coef_q  [NUM_TAPS];

    // Datapath intermediates
    logic                    accept;
    logic                    coef_wr;
    logic [3:0]              d_req;
    logic [3:0]              d_cur;
    logic                    last_phase;
    logic [TAP_W-1:0]        rd_idx;
    logic signed [PROD_W-1:0] coef_ext, samp_ext, prod;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W:0]   rnd_sum, rnd_shift;
    logic [DATA_W-1:0]       sat_val;

    assign accept  = (state_q == ST_IDLE) && audio_valid_in;
    assign coef_wr = (state_q == ST_IDLE) && coef_we_in;

    // Effective decimation factor requested on the input this cycle.
    always_comb begin
        if (dec_factor_in <= 4'd1) begin
            d_req = 4'd1;
        end else if (dec_factor_in > MAX_DEC_L) begin
            d_req = MAX_DEC_L;
        end else begin
            d_req = dec_factor_in;
        end
    end

    // D is only re-sampled at the start of a decimation period, so a change
    // on dec_factor_in never shortens or stretches the period in progress.
    assign d_cur      = (phase_q == 4'd0) ? d_req : d_eff_q;
    assign last_phase = (phase_q == d_cur - 4'd1);

    // Tap 0 addresses the newest sample, which sits just behind wr_ptr.
    // The pointer arithmetic wraps naturally because NUM_TAPS is a power of two.
    assign rd_idx   = wr_ptr_q - TAP_W'(1) - tap_q;
    assign coef_ext = PROD_W'($signed(coef_q[tap_q]));
    assign samp_ext = PROD_W'($signed(dline_q[ch_q][rd_idx]));
    assign prod     = coef_ext * samp_ext;
    assign acc_sum  = acc_q + ACC_W'(prod);

    // Round half up, drop the Q1.(COEF_W-1) fraction, then clamp.
    assign rnd_sum   = (ACC_W+1)'(acc_q) + RND_BIAS;
    assign rnd_shift = rnd_sum >>> (COEF_W-1);

    always_comb begin
        if (rnd_shift > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (rnd_shift < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_val = rnd_shift[DATA_W-1:0];
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a hold default first so no path
        // through the case statement can leave a variable unassigned (latch).
        state_d     = state_q;
        phase_d     = phase_q;
        d_eff_d     = d_eff_q;
        wr_ptr_d    = wr_ptr_q;
        tap_d       = tap_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q | (audio_valid_in & busy_q);
        dec_out_d   = dec_out_q;
        dec_ch_d    = dec_ch_q;
        dec_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + TAP_W'(1);
                    if (phase_q == 4'd0) begin
                        d_eff_d = d_req;
                    end
                    if (last_phase) begin
                        phase_d = 4'd0;
                        ch_d    = '0;
                        tap_d   = '0;
                        acc_d   = '0;
                        busy_d  = 1'b1;
                        state_d = ST_MAC;
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == TAP_W'(NUM_TAPS-1)) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                dec_out_d   = sat_val;
                dec_ch_d    = ch_q;
                dec_valid_d = 1'b1;
                if (ch_q == CH_W'(NUM_CH-1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    tap_d   = '0;
                    acc_d   = '0;
                    state_d = ST_MAC;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: the delay lines and coefficient bank are cleared in reset as well,
    // so a reset mid-operation cannot leave stale history or taps behind; this
    // keeps them in flops rather than a RAM macro.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    dline_q[c][t] <= '0;
                end
            end
            for (int t = 0; t < NUM_TAPS; t++) begin
                coef_q[t] <= '0;
            end
        end else begin
            if (accept) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    dline_q[c][wr_ptr_q] <= audio_in[c*DATA_W +: DATA_W];
                end
            end
            if (coef_wr) begin
                coef_q[coef_addr_in] <= coef_data_in;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            phase_q     <= 4'd0;
            d_eff_q     <= 4'd1;
            wr_ptr_q    <= '0;
            tap_q       <= '0;
            ch_q        <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            dec_out_q   <= '0;
            dec_ch_q    <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            d_eff_q     <= d_eff_d;
            wr_ptr_q    <= wr_ptr_d;
            tap_q       <= tap_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            dec_out_q   <= dec_out_d;
            dec_ch_q    <= dec_ch_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    assign dec_out       = dec_out_q;
    assign dec_ch_out    = dec_ch_q;
    assign dec_valid_out = dec_valid_q;
    assign busy_out      = busy_q;
    assign overrun_out   = overrun_q;

endmodule
